// File: rtl/core_pkg.sv
// core_pkg: shared rename-stage constants and register index types
package core_pkg;
    localparam int ARCH_REGS = 32;
    localparam int PHYS_REGS = 64;
    localparam int PREG_W    = 6;
    localparam int AREG_W    = 5;
    localparam int FL_DEPTH  = PHYS_REGS - ARCH_REGS;
    localparam int FL_PTR_W  = $clog2(FL_DEPTH);

    typedef logic [PREG_W-1:0]   preg_t;
    typedef logic [AREG_W-1:0]   areg_t;
    typedef logic [FL_PTR_W-1:0] fl_ptr_t;
    typedef logic [FL_PTR_W:0]   fl_cnt_t;
endpackage

// File: rtl/rn_free_list.sv
// rn_free_list: circular FIFO of free physical registers, reset to p32..p63
module rn_free_list
    import core_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pop,
    input  logic              push,
    input  logic [PREG_W-1:0] push_p,
    output logic [PREG_W-1:0] pop_p,
    output logic [FL_PTR_W:0] count
);
    preg_t   mem_q [FL_DEPTH];
    preg_t   mem_d [FL_DEPTH];
    fl_ptr_t head_q, head_d, tail_q, tail_d;
    fl_cnt_t count_q, count_d;
    logic    do_pop, do_push;

    assign do_pop  = pop && count_q != '0;
    assign do_push = push && count_q != fl_cnt_t'(FL_DEPTH);
    assign pop_p   = mem_q[head_q];
    assign count   = count_q;

    // Pointers wrap naturally because FL_DEPTH is a power of two; an overflowing push is dropped
    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[tail_q] = push_p;
        head_d  = head_q + fl_ptr_t'(do_pop);
        tail_d  = tail_q + fl_ptr_t'(do_push);
        count_d = count_q + fl_cnt_t'(do_push) - fl_cnt_t'(do_pop);
    end

    // State register; reset fills the list with every register above the architectural range
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FL_DEPTH; i++) mem_q[i] <= preg_t'(ARCH_REGS + i);
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= fl_cnt_t'(FL_DEPTH);
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && count_q == fl_cnt_t'(FL_DEPTH)))
        else $error("free list overflow: push while full");
endmodule

// File: rtl/rename_unit.sv
// rename_unit: RAT lookup, physical rd allocation and registered ISQ output stage
module rename_unit
    import core_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id2rn_valid,
    input  logic [AREG_W-1:0] id2rn_rs1,
    input  logic [AREG_W-1:0] id2rn_rs2,
    input  logic [AREG_W-1:0] id2rn_rd,
    input  logic              id2rn_reg_write,
    output logic              rn2id_ready,
    output logic              rn2iq_valid,
    output logic [PREG_W-1:0] rn2iq_rs1_p,
    output logic [PREG_W-1:0] rn2iq_rs2_p,
    output logic [PREG_W-1:0] rn2iq_rd_p,
    output logic [PREG_W-1:0] rn2iq_old_rd_p,
    input  logic              iq2rn_ready,
    input  logic              rob2rn_free_valid,
    input  logic [PREG_W-1:0] rob2rn_free_p
);
    preg_t   rat_q [ARCH_REGS];
    preg_t   rat_d [ARCH_REGS];
    logic    valid_q, valid_d;
    preg_t   rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d, old_q, old_d;
    preg_t   fl_head_p;
    fl_cnt_t fl_count;
    logic    accept, alloc, free_push;

    // Ready is conservative: any instruction stalls on an empty list, and nothing is ready in reset
    assign rn2id_ready = rst_n && (!valid_q || iq2rn_ready) && fl_count != '0;
    assign accept      = id2rn_valid && rn2id_ready;
    assign alloc       = accept && id2rn_reg_write && id2rn_rd != '0;
    assign free_push   = rob2rn_free_valid && rob2rn_free_p != '0;

    rn_free_list u_free_list (
        .clk    (clk),
        .rst_n  (rst_n),
        .pop    (alloc),
        .push   (free_push),
        .push_p (rob2rn_free_p),
        .pop_p  (fl_head_p),
        .count  (fl_count)
    );

    // Sources read the pre-update RAT, so an instruction never sees its own rd mapping
    always_comb begin
        rat_d   = rat_q;
        valid_d = accept ? 1'b1 : (iq2rn_ready ? 1'b0 : valid_q);
        rs1_d   = accept ? rat_q[id2rn_rs1] : rs1_q;
        rs2_d   = accept ? rat_q[id2rn_rs2] : rs2_q;
        rd_d    = accept ? (alloc ? fl_head_p : '0) : rd_q;
        old_d   = accept ? (alloc ? rat_q[id2rn_rd] : '0) : old_q;
        if (alloc) rat_d[id2rn_rd] = fl_head_p;
    end

    // RAT and output stage; reset restores the identity map and discards any in-flight output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ARCH_REGS; i++) rat_q[i] <= preg_t'(i);
            valid_q <= 1'b0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            old_q   <= '0;
        end else begin
            rat_q   <= rat_d;
            valid_q <= valid_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            old_q   <= old_d;
        end
    end

    assign rn2iq_valid    = valid_q;
    assign rn2iq_rs1_p    = rs1_q;
    assign rn2iq_rs2_p    = rs2_q;
    assign rn2iq_rd_p     = rd_q;
    assign rn2iq_old_rd_p = old_q;
endmodule

// File: tb/tb_rename_unit.sv
// tb_rename_unit: scoreboard bench with a queue-based RAT/free-list reference model
module tb_rename_unit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id2rn_valid = 1'b0;
    logic [4:0] id2rn_rs1 = '0, id2rn_rs2 = '0, id2rn_rd = '0;
    logic       id2rn_reg_write = 1'b0;
    logic       rn2id_ready, rn2iq_valid;
    logic [5:0] rn2iq_rs1_p, rn2iq_rs2_p, rn2iq_rd_p, rn2iq_old_rd_p;
    logic       iq2rn_ready = 1'b1;
    logic       rob2rn_free_valid = 1'b0;
    logic [5:0] rob2rn_free_p = '0;

    rename_unit dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .id2rn_valid       (id2rn_valid),
        .id2rn_rs1         (id2rn_rs1),
        .id2rn_rs2         (id2rn_rs2),
        .id2rn_rd          (id2rn_rd),
        .id2rn_reg_write   (id2rn_reg_write),
        .rn2id_ready       (rn2id_ready),
        .rn2iq_valid       (rn2iq_valid),
        .rn2iq_rs1_p       (rn2iq_rs1_p),
        .rn2iq_rs2_p       (rn2iq_rs2_p),
        .rn2iq_rd_p        (rn2iq_rd_p),
        .rn2iq_old_rd_p    (rn2iq_old_rd_p),
        .iq2rn_ready       (iq2rn_ready),
        .rob2rn_free_valid (rob2rn_free_valid),
        .rob2rn_free_p     (rob2rn_free_p)
    );

    always #5 clk = ~clk;

    typedef struct { int rs1; int rs2; int rd; int old; } exp_t;

    int   tests = 0;
    int   fails = 0;
    int   rat [32];
    int   fl [$];
    int   pool [$];
    exp_t sbq [$];
    bit   m_valid;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) rat[i] = i;
        fl.delete();
        for (int i = 32; i < 64; i++) fl.push_back(i);
        pool.delete();
        sbq.delete();
        m_valid = 0;
    endtask

    function automatic int out_pack();
        return int'({rn2iq_rs1_p, rn2iq_rs2_p, rn2iq_rd_p, rn2iq_old_rd_p});
    endfunction

    // One clock of stimulus; the model decides acceptance from its own view of ready
    task automatic step(input bit v, input int r1, input int r2, input int rd, input bit rw,
                        input bit iqr, input bit fv, input int fp);
        bit   exp_ready;
        exp_t e;
        int   idx [$];
        @(posedge clk);
        #1;
        id2rn_valid       = v;
        id2rn_rs1         = 5'(r1);
        id2rn_rs2         = 5'(r2);
        id2rn_rd          = 5'(rd);
        id2rn_reg_write   = rw;
        iq2rn_ready       = iqr;
        rob2rn_free_valid = fv;
        rob2rn_free_p     = 6'(fp);
        #3;
        exp_ready = (!m_valid || iqr) && fl.size() != 0;
        chk(rn2id_ready == exp_ready, "ready", int'(rn2id_ready), int'(exp_ready));
        chk(rn2iq_valid == m_valid, "valid", int'(rn2iq_valid), int'(m_valid));
        if (v && exp_ready) begin
            e.rs1 = rat[r1];
            e.rs2 = rat[r2];
            e.rd  = 0;
            e.old = 0;
            if (rw && rd != 0) begin
                e.rd    = fl.pop_front();
                e.old   = rat[rd];
                rat[rd] = e.rd;
                pool.push_back(e.old);
            end
            sbq.push_back(e);
            m_valid = 1;
        end else if (iqr) begin
            m_valid = 0;
        end
        if (fv && fp != 0) begin
            fl.push_back(fp);
            idx = pool.find_first_index(x) with (x == fp);
            if (idx.size() != 0) pool.delete(idx[0]);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n             = 1'b0;
        id2rn_valid       = 1'b0;
        rob2rn_free_valid = 1'b0;
        iq2rn_ready       = 1'b1;
        #1;
        chk(rn2iq_valid == 1'b0, "rst_valid", int'(rn2iq_valid), 0);
        chk(rn2id_ready == 1'b0, "rst_ready", int'(rn2id_ready), 0);
        chk(out_pack() == 0, "rst_outputs", out_pack(), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: every handshake must match the oldest expected rename
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rn2iq_valid && iq2rn_ready) begin
                if (sbq.size() == 0) begin
                    chk(1'b0, "unexpected_output", out_pack(), 0);
                end else begin
                    e = sbq.pop_front();
                    chk(out_pack() == ((e.rs1 << 18) | (e.rs2 << 12) | (e.rd << 6) | e.old),
                        "handshake", out_pack(), (e.rs1 << 18) | (e.rs2 << 12) | (e.rd << 6) | e.old);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap, r1, r2, rd, fp;
        bit v, rw, iqr, fv;
        model_reset();

        // add x1,x2,x3 after reset
        do_reset();
        step(1, 2, 3, 1, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        chk(rn2iq_valid == 1'b1, "add_valid", int'(rn2iq_valid), 1);
        chk(out_pack() == ((2 << 18) | (3 << 12) | (32 << 6) | 1), "add_fields", out_pack(),
            (2 << 18) | (3 << 12) | (32 << 6) | 1);

        // back-to-back x1<-x1 then x4<-x1
        do_reset();
        step(1, 1, 0, 1, 1, 1, 0, 0);
        step(1, 1, 0, 4, 1, 1, 0, 0);
        chk(rn2iq_rs1_p == 1 && rn2iq_rd_p == 32, "b2b_first", out_pack(), (1 << 18) | (32 << 6) | 1);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        chk(rn2iq_rs1_p == 32 && rn2iq_rd_p == 33 && rn2iq_old_rd_p == 4, "b2b_second", out_pack(),
            (32 << 18) | (33 << 6) | 4);

        // rd = x0 allocates nothing
        do_reset();
        step(1, 5, 6, 0, 1, 1, 0, 0);
        step(1, 7, 8, 2, 1, 1, 0, 0);
        chk(rn2iq_rd_p == 0 && rn2iq_old_rd_p == 0, "x0_rd", out_pack(), (5 << 18) | (6 << 12));
        step(0, 0, 0, 0, 0, 1, 0, 0);
        chk(rn2iq_rd_p == 32, "x0_no_pop", int'(rn2iq_rd_p), 32);

        // drain the free list, then a single free re-enables rename
        do_reset();
        for (int i = 0; i < 32; i++) step(1, 0, 0, (i % 31) + 1, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1, 7);
        chk(rn2id_ready == 1'b0, "empty_stall", int'(rn2id_ready), 0);
        step(1, 0, 0, 3, 1, 1, 0, 0);
        chk(rn2id_ready == 1'b1, "refill_ready", int'(rn2id_ready), 1);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        chk(rn2iq_rd_p == 7, "refill_rd", int'(rn2iq_rd_p), 7);

        // output stall holds everything stable for three cycles
        do_reset();
        step(1, 3, 4, 5, 1, 1, 0, 0);
        step(1, 6, 7, 8, 1, 0, 0, 0);
        snap = out_pack();
        step(1, 6, 7, 8, 1, 0, 0, 0);
        step(1, 6, 7, 8, 1, 0, 0, 0);
        chk(out_pack() == snap, "stall_stable", out_pack(), snap);
        chk(rn2id_ready == 1'b0, "stall_ready", int'(rn2id_ready), 0);
        step(1, 6, 7, 8, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        chk(rn2iq_rd_p == 33, "stall_no_alloc", int'(rn2iq_rd_p), 33);

        // simultaneous pop and push at count 5, then reset mid-stream
        do_reset();
        for (int i = 0; i < 27; i++) step(1, 0, 0, (i % 9) + 1, 1, 1, 0, 0);
        step(1, 0, 0, 10, 1, 1, 1, 40);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 11 + i, 1, 1, 0, 0);
        step(1, 1, 2, 20, 1, 1, 0, 0);
        chk(rn2iq_rd_p == 40, "pushpop_order", int'(rn2iq_rd_p), 40);
        do_reset();
        step(1, 9, 10, 9, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        chk(out_pack() == ((9 << 18) | (10 << 12) | (32 << 6) | 9), "post_reset_rat", out_pack(),
            (9 << 18) | (10 << 12) | (32 << 6) | 9);

        // randomized traffic with legal frees of retired mappings
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            v   = $urandom_range(0, 3) != 0;
            r1  = int'($urandom_range(0, 31));
            r2  = int'($urandom_range(0, 31));
            rd  = int'($urandom_range(0, 31));
            rw  = $urandom_range(0, 1) == 1;
            iqr = $urandom_range(0, 3) != 0;
            fv  = 0;
            fp  = 0;
            if (pool.size() != 0 && $urandom_range(0, 1) == 1) begin
                fv = 1;
                fp = pool[$urandom_range(0, pool.size() - 1)];
            end else if ($urandom_range(0, 15) == 0) begin
                fv = 1;
            end
            step(v, r1, r2, rd, rw, iqr, fv, fp);
        end
        repeat (3) step(0, 0, 0, 0, 0, 1, 0, 0);
        chk(sbq.size() == 0, "drain_empty", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rename_unit.md
Name: rename_unit

Overview:
- Register-rename stage between the decoder (IDU) and the issue queue (ISQ) of the out-of-order RV32 core.
- Maps architectural rs1/rs2/rd to physical registers using a register alias table (RAT) and allocates a fresh physical rd from a circular free list.
- Returns physical registers released by the ROB at commit to the free list.
- Presents one renamed instruction per cycle to the ISQ through a registered valid/ready stage.

Parameters:
- ARCH_REGS, 32, number of architectural registers.
- PHYS_REGS, 64, number of physical registers.
- PREG_W, 6, physical register index width (log2 PHYS_REGS).
- FL_DEPTH, 32, free-list capacity (PHYS_REGS - ARCH_REGS).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- id2rn_valid  in  1  decoded instruction valid
- id2rn_rs1  in  5  architectural rs1
- id2rn_rs2  in  5  architectural rs2
- id2rn_rd  in  5  architectural rd
- id2rn_reg_write  in  1  instruction writes rd
- rn2id_ready  out  1  rename can accept this cycle
- rn2iq_valid  out  1  renamed instruction valid
- rn2iq_rs1_p  out  PREG_W  physical rs1
- rn2iq_rs2_p  out  PREG_W  physical rs2
- rn2iq_rd_p  out  PREG_W  physical rd (0 when no write)
- rn2iq_old_rd_p  out  PREG_W  previous mapping of rd, sent to ROB for freeing at commit
- iq2rn_ready  in  1  ISQ accepts the output this cycle
- rob2rn_free_valid  in  1  commit releases one physical register
- rob2rn_free_p  in  PREG_W  physical register released

Behaviour:
- Reset state:
  - RAT[i] = i for all i.
  - Free list holds p32..p63 in order: head=0, tail=0, count=32.
  - All outputs 0; rn2id_ready is 0 during reset.
- Accept rule:
  - accept = id2rn_valid && rn2id_ready.
  - rn2id_ready = (!rn2iq_valid || iq2rn_ready) && (fl_count != 0).
  - Ready is conservative: it stalls on an empty free list even when reg_write=0. It does not depend on id2rn_* inputs.
- Allocation:
  - alloc = accept && id2rn_reg_write && id2rn_rd != 0.
  - On alloc: pop the head entry, RAT[rd] <= popped, rn2iq_rd_p <= popped, rn2iq_old_rd_p <= RAT[rd] (pre-update).
  - Otherwise rd_p = 0 and old_rd_p = 0.
- Source lookup:
  - rs1_p/rs2_p read the RAT before this cycle's update. Example: add x5,x5,x5 reads the old x5 mapping.
  - x0 always reads p0; RAT[0] is never written.
- Latency: 1 cycle. Outputs are registered on accept.
  - If !accept and iq2rn_ready, rn2iq_valid <= 0.
  - If stalled (valid && !ready), all outputs hold stable.
- Back-to-back:
  - Instruction N+1 accepted the cycle after N sees N's RAT update; no bypass needed.
- Free:
  - On rob2rn_free_valid with free_p != 0: push at tail, tail wraps mod FL_DEPTH.
  - free_p == 0 is ignored.
- Simultaneous pop and push:
  - count unchanged; head and tail both advance.
  - A register freed in a cycle when count==0 becomes allocatable the next cycle, since ready uses registered count.
- Overflow: a push while count==FL_DEPTH is illegal. The push is dropped and a simulation assertion fires.
- Pointers wrap: head/tail are log2(FL_DEPTH) bits; count is log2(FL_DEPTH)+1 bits.
- Reset mid-operation: RAT, free list and output stage return to reset values immediately; an in-flight output is discarded.
- Flush/checkpoint recovery is out of scope for this revision.

Decomposition:
- Shared package core_pkg:
  - Constants ARCH_REGS, PHYS_REGS, PREG_W, AREG_W=5.
  - typedef preg_t (logic [PREG_W-1:0]).
  - typedef areg_t (logic [4:0]).
- One sub-module: rn_free_list. It is a circular FIFO with pop/push/count, reset-initialised to p32..p63. The RAT and the output stage stay in rename_unit.

Test Plan:
- Reset, then rename add x1,x2,x3 (reg_write=1) with iq2rn_ready=1 -> next cycle valid=1, rs1_p=2, rs2_p=3, rd_p=32, old_rd_p=1.
- Rename x1<-x1, then x4<-x1 back-to-back -> first: rs1_p=1, rd_p=32; second: rs1_p=32, rd_p=33, old_rd_p=4.
- Instruction with rd=x0 and reg_write=1 -> rd_p=0, old_rd_p=0, fl_count stays 32.
- 32 allocating renames with no frees -> rn2id_ready=0 on the 33rd cycle.
  - Then free p7 -> ready=1 the next cycle, and the next rd_p=7.
- Hold iq2rn_ready=0 for 3 cycles with id2rn_valid=1 -> outputs stable, no allocation (count unchanged), rn2id_ready=0.
- Same-cycle alloc and free of p40 at count=5 -> count stays 5; p40 is returned after the 5 queued entries. Then assert rst_n=0 mid-stream -> RAT identity, count=32, rn2iq_valid=0.
